lzd_shift_ctrl: RTL and testbench
=================================

// Module: lzd_shift_ctrl
// PURPOSE
//  Sequential leading-zero detector; produces the normalization shift command for the mantissa barrel shifter.
//  Scans the adder/subtractor result (carry bit + SW-bit significand) SEG bits per cycle, MSB first.
//  Emits shift amount, direction and zero flag with a valid/ack handshake.
//  Sits between the add/sub datapath and the shifter's Shift_Value_1 / left-right control inputs.
// PARAMETERS
//  SW   26  significand width incl. implicit, guard and round bits (52+3 for double)
//  EW   8   shift-value width; must satisfy 2^EW > SW
//  SEG  4   bits examined per scan cycle; 1 <= SEG <= SW
// PORTS
//  clk                 in   1     clock, rising edge
//  rst                 in   1     asynchronous reset, active-low
//  start_i             in   1     capture Add_Subt_result_i; honoured in IDLE only
//  Add_Subt_result_i   in   SW+1  bit SW = carry-out, bits SW-1..0 = significand
//  ack_i               in   1     consumer has taken the result
//  ready_o             out  1     1 in IDLE (start_i will be accepted)
//  valid_o             out  1     result valid; held until ack_i
//  Shift_Value_o       out  EW    normalization shift amount
//  Left_Right_o        out  1     1 = shift left, 0 = shift right
//  Zero_flag_o         out  1     significand and carry all zero
// BEHAVIOUR
//  Reset (rst=0, any state, async): state=IDLE; ready_o=1; valid_o=0; Shift_Value_o=0; Left_Right_o=0; Zero_flag_o=0; data/count regs cleared.
//  FSM states: IDLE, SCAN, DONE.
//  IDLE: start_i=1 -> register input; carry=1 -> DONE with Shift_Value_o=1, Left_Right_o=0 (right shift by 1);
//    carry=0 -> SCAN with seg_idx=0, lz=0. start_i=0 -> remain IDLE.
//  SCAN: each cycle examine bits [SW-1-SEG*seg_idx -: SEG] (last segment truncated to SW mod SEG bits when nonzero).
//    Segment contains a one: lz += position of its highest one within the segment; found=1; lz frozen thereafter.
//    Segment all zero and found=0: lz += segment width.
//    After last segment (N_SEG = ceil(SW/SEG)) -> DONE.
//  DONE result: found=1 -> Shift_Value_o=lz, Left_Right_o=1, Zero_flag_o=0; found=0 -> Shift_Value_o=0, Left_Right_o=1, Zero_flag_o=1.
//  valid_o=1 only in DONE; outputs stable while valid_o=1. ack_i=1 in DONE -> IDLE next cycle (outputs retained, valid_o=0).
//  start_i outside IDLE is ignored (no queuing); ack_i outside DONE is ignored.
//  Latency (start_i cycle = 0): carry case valid_o at cycle 1; otherwise valid_o at cycle N_SEG+1 (fixed).
//  Earliest re-accept: start_i in cycle after ack_i. lz never exceeds SW-1; saturation logic not required.
//  Input register is a snapshot; Add_Subt_result_i changes after capture have no effect.
// CONFIGURATION
//  LZD_EARLY_EXIT_EN defined: SCAN -> DONE in the same cycle the first one-bearing segment is processed;
//    latency = k+1, k = 1-based index of that segment (all-zero input still takes N_SEG+1).
//  Undefined: always scans all N_SEG segments; fixed latency N_SEG+1 for every non-carry input.
//  Result values identical in both builds; only valid_o timing differs.
// TESTING (SW=26, EW=8, SEG=4, N_SEG=7)
//  1. input 27'h4000000 (carry) -> valid_o at cycle 1, Shift_Value_o=1, Left_Right_o=0, Zero_flag_o=0.
//  2. input 27'h0400000 (bit 22) -> Shift_Value_o=3, Left_Right_o=1; valid_o cycle 8 (cycle 2 with LZD_EARLY_EXIT_EN).
//  3. input 27'h0000001 -> Shift_Value_o=25, Left_Right_o=1; valid_o cycle 8 in both builds.
//  4. input 27'h0 -> Zero_flag_o=1, Shift_Value_o=0, valid_o cycle 8.
//  5. Hold ack_i=0 for 5 cycles in DONE -> valid_o and outputs stable; start_i pulses ignored; ack_i -> ready_o=1 next cycle.
//  6. Drive rst=0 mid-SCAN -> outputs to reset values immediately; after release, new start_i yields correct result.

Source files
------------

// File: rtl/lzd_shift_ctrl.sv
// lzd_shift_ctrl: segmented MSB-first leading-zero scan driving the mantissa shifter.
// Optional build: define LZD_EARLY_EXIT_EN to finish on the first one-bearing segment.
module lzd_shift_ctrl #(
  parameter int SW  = 26,
  parameter int EW  = 8,
  parameter int SEG = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [SW:0]   Add_Subt_result_i,
  input  logic          ack_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [EW-1:0] Shift_Value_o,
  output logic          Left_Right_o,
  output logic          Zero_flag_o
);

  localparam int N_SEG  = (SW + SEG - 1) / SEG;
  localparam int LAST_W = (SW % SEG == 0) ? SEG : SW % SEG;
  localparam int IW     = $clog2(N_SEG + 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t         state_q, state_n;
  logic [SW-1:0]  data_q, data_n;
  logic [EW-1:0]  lz_q, lz_n;
  logic           found_q, found_n;
  logic [IW-1:0]  idx_q, idx_n;
  logic [EW-1:0]  sv_n;
  logic           lr_n, zf_n;

  logic [SEG-1:0] seg;
  logic [EW-1:0]  pos, seg_w, lz_sum;
  logic           has_one, last, early;

`ifdef LZD_EARLY_EXIT_EN
  assign early = has_one;
`else
  assign early = 1'b0;
`endif

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);

  // data_q is shifted up each scan cycle, so the window is always its top SEG bits;
  // the truncated last segment sees zero padding below its valid bits.
  always_comb begin
    seg     = data_q[SW-1 -: SEG];
    has_one = |seg;
    last    = (idx_q == IW'(N_SEG - 1));
    seg_w   = last ? EW'(LAST_W) : EW'(SEG);
    pos     = '0;
    for (int i = 0; i < SEG; i++) begin
      if (seg[i]) pos = EW'(SEG - 1 - i);
    end
    if (found_q)      lz_sum = lz_q;
    else if (has_one) lz_sum = lz_q + pos;
    else              lz_sum = lz_q + seg_w;
  end

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    lz_n    = lz_q;
    found_n = found_q;
    idx_n   = idx_q;
    sv_n    = Shift_Value_o;
    lr_n    = Left_Right_o;
    zf_n    = Zero_flag_o;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          data_n  = Add_Subt_result_i[SW-1:0];
          lz_n    = '0;
          found_n = 1'b0;
          idx_n   = '0;
          if (Add_Subt_result_i[SW]) begin
            state_n = DONE;
            sv_n    = EW'(1);
            lr_n    = 1'b0;
            zf_n    = 1'b0;
          end else begin
            state_n = SCAN;
          end
        end
      end
      SCAN: begin
        data_n  = data_q << SEG;
        lz_n    = lz_sum;
        found_n = found_q | has_one;
        idx_n   = idx_q + 1'b1;
        if (last || early) begin
          state_n = DONE;
          sv_n    = found_n ? lz_sum : '0;
          lr_n    = 1'b1;
          zf_n    = ~found_n;
        end
      end
      DONE: begin
        if (ack_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      lz_q          <= '0;
      found_q       <= 1'b0;
      idx_q         <= '0;
      Shift_Value_o <= '0;
      Left_Right_o  <= 1'b0;
      Zero_flag_o   <= 1'b0;
    end else begin
      state_q       <= state_n;
      data_q        <= data_n;
      lz_q          <= lz_n;
      found_q       <= found_n;
      idx_q         <= idx_n;
      Shift_Value_o <= sv_n;
      Left_Right_o  <= lr_n;
      Zero_flag_o   <= zf_n;
    end
  end

endmodule

// File: tb/tb_lzd_shift_ctrl.sv
// tb_lzd_shift_ctrl: vector table, corner sequences and random
// stimulus against a highest-set-bit reference model.
module tb_lzd_shift_ctrl;

  localparam int SW    = 26;
  localparam int EW    = 8;
  localparam int SEG   = 4;
  localparam int N_SEG = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [SW:0]   res;
  logic          ack_i;
  logic          ready_o;
  logic          valid_o;
  logic [EW-1:0] Shift_Value_o;
  logic          Left_Right_o;
  logic          Zero_flag_o;

  int checks = 0;
  int errors = 0;

  lzd_shift_ctrl #(.SW(SW), .EW(EW), .SEG(SEG)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .Add_Subt_result_i(res),
    .ack_i            (ack_i),
    .ready_o          (ready_o),
    .valid_o          (valid_o),
    .Shift_Value_o    (Shift_Value_o),
    .Left_Right_o     (Left_Right_o),
    .Zero_flag_o      (Zero_flag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW:0]   din;
    logic [EW-1:0] sv;
    logic          lr;
    logic          zf;
    int            lat_d;
    int            lat_e;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: normalization from the index of the highest set bit.
  function automatic void model(input logic [SW:0] d,
                                output logic [EW-1:0] sv,
                                output logic lr, output logic zf,
                                output int lat);
    int b;
    b = -1;
    for (int i = 0; i < SW; i++) if (d[i]) b = i;
    if (d[SW]) begin
      sv = 1; lr = 0; zf = 0; lat = 1;
    end else if (b < 0) begin
      sv = 0; lr = 1; zf = 1; lat = N_SEG + 1;
    end else begin
      sv = EW'(SW - 1 - b); lr = 1; zf = 0;
`ifdef LZD_EARLY_EXIT_EN
      lat = (SW - 1 - b) / SEG + 2;
`else
      lat = N_SEG + 1;
`endif
    end
  endfunction

  task automatic run_check(input logic [SW:0] din,
                           input logic [EW-1:0] esv,
                           input logic elr, input logic ezf,
                           input int elat, input string nm,
                           input int hold);
    int cnt;
    @(negedge clk);
    chk({nm, "_ready"}, int'(ready_o), 1);
    start_i = 1'b1;
    res     = din;
    @(negedge clk);
    start_i = 1'b0;
    res     = (SW+1)'($urandom);
    cnt     = 1;
    while (!valid_o && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, "_lat"}, cnt, elat);
    chk({nm, "_sv"}, int'(Shift_Value_o), int'(esv));
    chk({nm, "_lr"}, int'(Left_Right_o), int'(elr));
    chk({nm, "_zf"}, int'(Zero_flag_o), int'(ezf));
    for (int h = 0; h < hold; h++) begin
      start_i = 1'b1;
      res     = (SW+1)'($urandom);
      @(negedge clk);
      chk({nm, "_hold_valid"}, int'(valid_o), 1);
      chk({nm, "_hold_sv"}, int'(Shift_Value_o), int'(esv));
      chk({nm, "_hold_zf"}, int'(Zero_flag_o), int'(ezf));
    end
    start_i = 1'b0;
    ack_i   = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    chk({nm, "_ack_ready"}, int'(ready_o), 1);
    chk({nm, "_ack_valid"}, int'(valid_o), 0);
    chk({nm, "_ack_sv"}, int'(Shift_Value_o), int'(esv));
  endtask

  initial begin
    logic [SW:0]   d;
    logic [EW-1:0] msv;
    logic          mlr, mzf;
    int            mlat;

    vecs[0] = '{27'h4000000, 8'd1,  1'b0, 1'b0, 1, 1};
    vecs[1] = '{27'h0400000, 8'd3,  1'b1, 1'b0, 8, 2};
    vecs[2] = '{27'h0000001, 8'd25, 1'b1, 1'b0, 8, 8};
    vecs[3] = '{27'h0000000, 8'd0,  1'b1, 1'b1, 8, 8};
    vecs[4] = '{27'h2000000, 8'd0,  1'b1, 1'b0, 8, 2};
    vecs[5] = '{27'h0000010, 8'd21, 1'b1, 1'b0, 8, 7};
    vecs[6] = '{27'h7ffffff, 8'd1,  1'b0, 1'b0, 1, 1};
    vecs[7] = '{27'h0000003, 8'd24, 1'b1, 1'b0, 8, 8};
    vecs[8] = '{27'h0123456, 8'd5,  1'b1, 1'b0, 8, 3};

    rst     = 1'b0;
    start_i = 1'b0;
    ack_i   = 1'b0;
    res     = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_sv", int'(Shift_Value_o), 0);
    chk("rst_lr", int'(Left_Right_o), 0);
    chk("rst_zf", int'(Zero_flag_o), 0);
    rst = 1'b1;

    // ack while idle must not disturb anything
    @(negedge clk);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    chk("idle_ack_ready", int'(ready_o), 1);
    chk("idle_ack_valid", int'(valid_o), 0);

    for (int i = 0; i < 9; i++) begin
`ifdef LZD_EARLY_EXIT_EN
      mlat = vecs[i].lat_e;
`else
      mlat = vecs[i].lat_d;
`endif
      run_check(vecs[i].din, vecs[i].sv, vecs[i].lr, vecs[i].zf,
                mlat, $sformatf("vec%0d", i), 0);
    end

    // long hold in DONE with ignored start pulses
    run_check(27'h0400000, 8'd3, 1'b1, 1'b0,
`ifdef LZD_EARLY_EXIT_EN
              2,
`else
              8,
`endif
              "hold5", 5);

    // leave nonzero outputs, then reset mid-scan
    run_check(27'h0000001, 8'd25, 1'b1, 1'b0, 8, "pre_rst", 0);
    @(negedge clk);
    start_i = 1'b1;
    res     = 27'h0000100;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_ready", int'(ready_o), 0);
    rst = 1'b0;
    #1;
    chk("arst_ready", int'(ready_o), 1);
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_sv", int'(Shift_Value_o), 0);
    chk("arst_lr", int'(Left_Right_o), 0);
    chk("arst_zf", int'(Zero_flag_o), 0);
    @(negedge clk);
    rst = 1'b1;
    model(27'h0000100, msv, mlr, mzf, mlat);
    run_check(27'h0000100, msv, mlr, mzf, mlat, "post_rst", 0);

    for (int r = 0; r < 60; r++) begin
      d = (SW+1)'($urandom) >> $urandom_range(0, SW + 1);
      if ($urandom_range(0, 3) != 0) d[SW] = 1'b0;
      model(d, msv, mlr, mzf, mlat);
      run_check(d, msv, mlr, mzf, mlat, $sformatf("rnd%0d", r),
                $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
